// File: rtl/input_port_router.sv
// Mesh router ingress port: buffers request packets in a small FIFO, computes an
// XY route from the head's destination tile and dispatches each packet as a one-cycle select.
module input_port_router #(
  parameter int unsigned NET_ADDR_W  = 4,
  parameter int unsigned BANK_ADDR_W = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NET_ADDR_W-1:0]             localAddress,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NET_ADDR_W+BANK_ADDR_W-1:0] in_destAddr,
  input  logic [NET_ADDR_W-1:0]             in_reqAddr,
  input  logic                              in_read,
  input  logic                              in_write,
  input  logic [DATA_W-1:0]                 in_data,
  input  logic [4:0]                        port_full,
  output logic [4:0]                        sel,
  output logic [NET_ADDR_W+BANK_ADDR_W-1:0] destAddrOut,
  output logic [NET_ADDR_W-1:0]             reqAddrOut,
  output logic                              readOut,
  output logic                              writeOut,
  output logic [DATA_W-1:0]                 dataOut,
  output logic                              err_malformed,
  output logic [7:0]                        dropCount
);

  localparam int unsigned DEST_W = NET_ADDR_W + BANK_ADDR_W;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned Y_W    = NET_ADDR_W / 2;
  localparam int unsigned X_W    = NET_ADDR_W - Y_W;

  typedef struct packed {
    logic [DEST_W-1:0]     destAddr;
    logic [NET_ADDR_W-1:0] reqAddr;
    logic                  read;
    logic                  write;
    logic [DATA_W-1:0]     data;
  } pkt_t;

  pkt_t             mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;

  pkt_t             headPkt;
  logic [X_W-1:0]   destX;
  logic [X_W-1:0]   localX;
  logic [Y_W-1:0]   destY;
  logic [Y_W-1:0]   localY;
  logic [4:0]       routeSel;
  logic             headValid;
  logic             malformed;
  logic             push;
  logic             popDispatch;
  logic             popDrop;
  logic             pop;

  assign in_ready  = !reset && (count < CNT_W'(DEPTH));
  assign push      = in_valid && in_ready;
  assign headPkt   = mem[rdPtr];
  assign headValid = (count != '0);
  assign malformed = (headPkt.read == headPkt.write);

  assign destX  = headPkt.destAddr[DEST_W-1 -: X_W];
  assign destY  = headPkt.destAddr[DEST_W-X_W-1 -: Y_W];
  assign localX = localAddress[NET_ADDR_W-1 -: X_W];
  assign localY = localAddress[Y_W-1:0];

  // XY routing: resolve X first, then Y; bit order {local, west, east, south, north}
  always_comb begin
    routeSel = 5'b10000;
    if (destX > localX)      routeSel = 5'b00100;
    else if (destX < localX) routeSel = 5'b01000;
    else if (destY > localY) routeSel = 5'b00010;
    else if (destY < localY) routeSel = 5'b00001;
  end

  // Malformed heads are dropped regardless of back-pressure
  assign popDrop     = headValid && malformed;
  assign popDispatch = headValid && !malformed && ((port_full & routeSel) == 5'b0);
  assign pop         = popDrop || popDispatch;

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= pkt_t'({in_destAddr, in_reqAddr, in_read, in_write, in_data});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  // Dispatch registers: fields hold their last value between packets
  always_ff @(posedge clk) begin
    if (reset) begin
      sel           <= '0;
      destAddrOut   <= '0;
      reqAddrOut    <= '0;
      readOut       <= 1'b0;
      writeOut      <= 1'b0;
      dataOut       <= '0;
      err_malformed <= 1'b0;
      dropCount     <= '0;
    end else begin
      sel           <= popDispatch ? routeSel : 5'b0;
      err_malformed <= popDrop;
      if (popDispatch) begin
        destAddrOut <= headPkt.destAddr;
        reqAddrOut  <= headPkt.reqAddr;
        readOut     <= headPkt.read;
        writeOut    <= headPkt.write;
        dataOut     <= headPkt.data;
      end
      if (popDrop && (dropCount != 8'hFF)) dropCount <= dropCount + 8'd1;
    end
  end

endmodule

// File: tb/tb_input_port_router.sv
// Randomized bench for input_port_router against a queue-based packet model
// that applies the routing, drop and back-pressure rules once per clock edge.
module tb_input_port_router;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [11:0] dest;
    logic [3:0]  req;
    logic        rd;
    logic        wr;
    logic [31:0] data;
  } pkt_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  localAddress;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_destAddr;
  logic [3:0]  in_reqAddr;
  logic        in_read;
  logic        in_write;
  logic [31:0] in_data;
  logic [4:0]  port_full;
  logic [4:0]  sel;
  logic [11:0] destAddrOut;
  logic [3:0]  reqAddrOut;
  logic        readOut;
  logic        writeOut;
  logic [31:0] dataOut;
  logic        err_malformed;
  logic [7:0]  dropCount;

  input_port_router #(.NET_ADDR_W(4), .BANK_ADDR_W(8), .DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .localAddress(localAddress),
    .in_valid(in_valid), .in_ready(in_ready), .in_destAddr(in_destAddr),
    .in_reqAddr(in_reqAddr), .in_read(in_read), .in_write(in_write), .in_data(in_data),
    .port_full(port_full), .sel(sel), .destAddrOut(destAddrOut), .reqAddrOut(reqAddrOut),
    .readOut(readOut), .writeOut(writeOut), .dataOut(dataOut),
    .err_malformed(err_malformed), .dropCount(dropCount)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  pkt_t q[$];
  pkt_t eLast;
  logic [4:0] eSel;
  logic       eErr;
  logic [7:0] eDrop;
  logic       eReady;
  logic [31:0] dispatched[$];

  // Target port index: 0 north, 1 south, 2 east, 3 west, 4 local
  function automatic int route(input logic [3:0] net);
    int dx, dy, lx, ly;
    dx = int'(net) / 4; dy = int'(net) % 4;
    lx = int'(localAddress) / 4; ly = int'(localAddress) % 4;
    if (dx > lx) return 2;
    if (dx < lx) return 3;
    if (dy > ly) return 1;
    if (dy < ly) return 0;
    return 4;
  endfunction

  function automatic pkt_t mk(input logic [3:0] net, input logic rd, input logic wr, input logic [31:0] data);
    pkt_t p;
    p.dest = {net, 8'($urandom)};
    p.req  = 4'($urandom);
    p.rd   = rd;
    p.wr   = wr;
    p.data = data;
    return p;
  endfunction

  function automatic logic [64:0] obsVec();
    return {sel, destAddrOut, reqAddrOut, readOut, writeOut, dataOut, err_malformed, dropCount, in_ready};
  endfunction

  function automatic logic [64:0] expVec();
    return {eSel, eLast, eErr, eDrop, eReady};
  endfunction

  task automatic drive(input pkt_t p, input logic v);
    in_valid    = v;
    in_destAddr = p.dest;
    in_reqAddr  = p.req;
    in_read     = p.rd;
    in_write    = p.wr;
    in_data     = p.data;
  endtask

  // Advance the model by one edge using the current inputs, then let the DUT take the edge
  task automatic tick();
    logic rdyBefore;
    pkt_t cur;
    pkt_t h;
    int   t;
    rdyBefore = !reset && (q.size() < DEPTH);
    cur = {in_destAddr, in_reqAddr, in_read, in_write, in_data};
    eSel = '0;
    eErr = 1'b0;
    if (reset) begin
      q.delete();
      eLast = '0;
      eDrop = '0;
    end else begin
      if (q.size() > 0) begin
        h = q[0];
        if (h.rd == h.wr) begin
          void'(q.pop_front());
          eErr = 1'b1;
          if (eDrop < 8'd255) eDrop = eDrop + 8'd1;
        end else begin
          t = route(h.dest[11:8]);
          if (!port_full[t]) begin
            void'(q.pop_front());
            eSel  = 5'(1 << t);
            eLast = h;
            dispatched.push_back(h.data);
          end
        end
      end
      if (in_valid && rdyBefore) q.push_back(cur);
    end
    @(posedge clk);
    #1;
    eReady = !reset && (q.size() < DEPTH);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    port_full = '0;
    drive(mk(4'h5, 1'b1, 1'b0, 32'h0), 1'b0);
    tick(); tick();
    vectors++;
    if (obsVec() !== 65'h0) begin
      miscompares++;
      $display("FAIL reset_state got=%h want=%h", obsVec(), 65'h0);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_routing();
    logic [3:0] nets [5];
    logic [4:0] sels [5];
    nets = '{4'b1001, 4'b0001, 4'b0110, 4'b0100, 4'b0101};
    sels = '{5'b00100, 5'b01000, 5'b00010, 5'b00001, 5'b10000};
    for (int i = 0; i < 7; i++) begin
      if (i < 5) drive(mk(nets[i], 1'b1, 1'b0, 32'(i + 100)), 1'b1);
      else       drive(mk(4'h0, 1'b0, 1'b0, 32'h0), 1'b0);
      tick();
      vectors++;
      if (obsVec() !== expVec()) begin
        miscompares++;
        $display("FAIL routing_cycle%0d got=%h want=%h", i, obsVec(), expVec());
      end
      if (i >= 1 && i <= 5) begin
        vectors++;
        if (sel !== sels[i-1] || dataOut !== 32'(i + 99)) begin
          miscompares++;
          $display("FAIL routing_sel%0d got=%b/%0d want=%b/%0d", i - 1, sel, dataOut, sels[i-1], i + 99);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    port_full = 5'b00100;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(mk(4'b1001, 1'b0, 1'b1, 32'(200 + i)), 1'b1);
      else       drive(mk(4'h0, 1'b0, 1'b0, 32'h0), 1'b0);
      tick();
      vectors++;
      if (obsVec() !== expVec()) begin
        miscompares++;
        $display("FAIL backpressure_fill%0d got=%h want=%h", i, obsVec(), expVec());
      end
    end
    vectors++;
    if (in_ready !== 1'b0 || sel !== 5'b0) begin
      miscompares++;
      $display("FAIL backpressure_full got=%b/%b want=0/00000", in_ready, sel);
    end
    port_full = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (sel !== 5'b00100 || dataOut !== 32'(200 + i) || obsVec() !== expVec()) begin
        miscompares++;
        $display("FAIL backpressure_drain%0d got=%h want=%h", i, obsVec(), expVec());
      end
    end
    tick();
    vectors++;
    if (in_ready !== 1'b1 || sel !== 5'b0) begin
      miscompares++;
      $display("FAIL backpressure_recover got=%b/%b want=1/00000", in_ready, sel);
    end
  endtask

  task automatic test_wrap();
    int sent = 0;
    int budget = 0;
    dispatched.delete();
    while ((sent < 10 || q.size() > 0) && budget < 200) begin
      port_full = ($urandom_range(0, 2) == 0) ? 5'b00100 : 5'b0;
      if (sent < 10) drive(mk(4'b1010, 1'b1, 1'b0, 32'(sent)), 1'b1);
      else           drive(mk(4'h0, 1'b0, 1'b0, 32'h0), 1'b0);
      if (sent < 10 && q.size() < DEPTH) sent++;
      tick();
      budget++;
      vectors++;
      if (obsVec() !== expVec()) begin
        miscompares++;
        $display("FAIL wrap_cycle%0d got=%h want=%h", budget, obsVec(), expVec());
      end
    end
    port_full = '0;
    tick();
    vectors++;
    if (dispatched.size() != 10) begin
      miscompares++;
      $display("FAIL wrap_count got=%0d want=10", dispatched.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        vectors++;
        if (dispatched[i] !== 32'(i)) begin
          miscompares++;
          $display("FAIL wrap_order%0d got=%0d want=%0d", i, dispatched[i], i);
        end
      end
    end
  endtask

  task automatic test_malformed();
    pkt_t seq [3];
    seq = '{mk(4'b0110, 1'b1, 1'b1, 32'hBAD1), mk(4'b0110, 1'b0, 1'b0, 32'hBAD2),
            mk(4'b0110, 1'b0, 1'b1, 32'h600D)};
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive(seq[i], 1'b1);
      else       drive(mk(4'h0, 1'b1, 1'b0, 32'h0), 1'b0);
      tick();
      vectors++;
      if (obsVec() !== expVec()) begin
        miscompares++;
        $display("FAIL malformed_cycle%0d got=%h want=%h", i, obsVec(), expVec());
      end
    end
    vectors++;
    if (dropCount !== 8'd2 || dataOut !== 32'h600D) begin
      miscompares++;
      $display("FAIL malformed_count got=%0d/%h want=2/600d", dropCount, dataOut);
    end
    for (int i = 0; i < 300; i++) begin
      drive(mk(4'($urandom), i[0], i[0], 32'(i)), 1'b1);
      tick();
      vectors++;
      if (obsVec() !== expVec()) begin
        miscompares++;
        $display("FAIL malformed_flood%0d got=%h want=%h", i, obsVec(), expVec());
      end
    end
    drive(mk(4'h0, 1'b0, 1'b0, 32'h0), 1'b0);
    tick(); tick();
    vectors++;
    if (dropCount !== 8'd255) begin
      miscompares++;
      $display("FAIL malformed_saturate got=%0d want=255", dropCount);
    end
  endtask

  task automatic test_reset_mid();
    port_full = 5'b00100;
    for (int i = 0; i < 3; i++) begin
      drive(mk(4'b1001, 1'b1, 1'b0, 32'(300 + i)), 1'b1);
      tick();
    end
    drive(mk(4'h0, 1'b0, 1'b0, 32'h0), 1'b0);
    reset = 1'b1;
    tick();
    vectors++;
    if (obsVec() !== 65'h0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs got=%h want=%h", obsVec(), 65'h0);
    end
    reset = 1'b0;
    port_full = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (sel !== 5'b0 || in_ready !== 1'b1 || obsVec() !== expVec()) begin
        miscompares++;
        $display("FAIL reset_mid_after%0d got=%h want=%h", i, obsVec(), expVec());
      end
    end
  endtask

  task automatic test_head_of_line();
    port_full = 5'b00100;
    for (int i = 0; i < 5; i++) begin
      if (i == 0)      drive(mk(4'b1101, 1'b1, 1'b0, 32'h0E0E), 1'b1);
      else if (i == 1) drive(mk(4'b0101, 1'b1, 1'b0, 32'h1C1C), 1'b1);
      else             drive(mk(4'h0, 1'b0, 1'b0, 32'h0), 1'b0);
      tick();
      vectors++;
      if (sel !== 5'b0 || obsVec() !== expVec()) begin
        miscompares++;
        $display("FAIL hol_blocked%0d got=%h want=%h", i, obsVec(), expVec());
      end
    end
    port_full = '0;
    tick();
    vectors++;
    if (sel !== 5'b00100 || dataOut !== 32'h0E0E) begin
      miscompares++;
      $display("FAIL hol_first got=%b/%h want=00100/0e0e", sel, dataOut);
    end
    tick();
    vectors++;
    if (sel !== 5'b10000 || dataOut !== 32'h1C1C) begin
      miscompares++;
      $display("FAIL hol_second got=%b/%h want=10000/1c1c", sel, dataOut);
    end
  endtask

  task automatic test_random();
    logic rd;
    logic wr;
    for (int i = 0; i < 300; i++) begin
      port_full = 5'($urandom) & 5'($urandom);
      rd = 1'($urandom);
      wr = ($urandom_range(0, 7) == 0) ? rd : !rd;
      drive(mk(4'($urandom), rd, wr, $urandom), 1'($urandom));
      tick();
      vectors++;
      if (obsVec() !== expVec()) begin
        miscompares++;
        $display("FAIL random_cycle%0d got=%h want=%h", i, obsVec(), expVec());
      end
    end
  endtask

  initial begin
    localAddress = 4'b0101;
    reset = 1'b1;
    port_full = '0;
    drive(mk(4'h0, 1'b0, 1'b0, 32'h0), 1'b0);
    test_reset();
    test_routing();
    test_backpressure();
    test_wrap();
    test_malformed();
    test_reset_mid();
    test_head_of_line();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/input_port_router.md
# input_port_router

Per-port ingress stage of the mesh router. It accepts request packets arriving on one link (N, S, E, W or local core), buffers them in a small FIFO and computes a dimension-ordered (XY) route from the destination network address. Each packet is then dispatched as a one-cycle select pulse, with its fields, to exactly one of the five output-port arbiters. Five instances sit in each router tile, directly upstream of the output-port arbiters.

## Interface
- NET_ADDR_W, 4: network (tile) address width; X = upper half, Y = lower half.
- BANK_ADDR_W, 8: cache-bank address width.
- DATA_W, 32: data width.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- localAddress  in  NET_ADDR_W  this tile's address; static while out of reset.
- in_valid  in  1  incoming packet valid.
- in_ready  out  1  router can accept a packet this cycle.
- in_destAddr  in  NET_ADDR_W+BANK_ADDR_W  destination; network address is the top NET_ADDR_W bits.
- in_reqAddr  in  NET_ADDR_W  requester tile address.
- in_read, in_write  in  1 each  request type.
- in_data  in  DATA_W  write data.
- port_full  in  5  arbiter back-pressure; bit order {local, west, east, south, north}.
- sel  out  5  one-hot dispatch pulse; same bit order as port_full.
- destAddrOut, reqAddrOut, readOut, writeOut, dataOut  out  widths as inputs  fields of the dispatched packet.
- err_malformed  out  1  one-cycle pulse when a malformed packet is dropped.
- dropCount  out  8  saturating count of dropped packets.

## Operation
- FIFO stores {destAddr, reqAddr, read, write, data}. Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH. An occupancy counter runs 0..DEPTH.
- Push occurs when in_valid && in_ready. in_ready = !reset && (count < DEPTH). There is no bypass when full, even if a pop happens in the same cycle.
- Route is computed combinationally from the FIFO head:
  - dX = dest X, lX = local X.
  - dX > lX: east. dX < lX: west.
  - Otherwise dY > lY: south; dY < lY: north; equal: local.
  - Comparisons are unsigned.
- Malformed packet: read == write (both 0 or both 1).
  - It is popped without back-pressure check; sel stays 0.
  - err_malformed pulses and dropCount increments, saturating at 255.
- Dispatch: the head is popped when non-empty, well-formed and port_full[target] == 0.
  - On the pop edge the output registers load the head fields and sel gets the one-hot target bit.
  - Otherwise sel goes to 0 and the field outputs hold their last value.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Head blocked by port_full: the head waits in place with no reordering and no bypass of later packets (head-of-line blocking is accepted).
- Reset: the FIFO is emptied, pointers and count go to 0, sel = 0, field outputs = 0, err_malformed = 0, dropCount = 0, in_ready = 0. Contents in flight when reset asserts are discarded.

## Timing
- A packet pushed at edge N is visible at the head in cycle N+1. If unblocked, sel and fields are registered at edge N+1, so they are valid throughout cycle N+1..N+2. Minimum latency is 2 edges.
- Throughput is one packet per cycle sustained while the target is not full.
- sel is high for exactly one cycle per packet; at most one bit is set.
- port_full is sampled in the same cycle as the pop decision. The arbiter must assert it early enough to absorb the pulse already issued.
- err_malformed is registered, asserting in the cycle after the drop pop edge.
- in_ready is combinational from count and reset only; it is independent of in_valid.

## Test plan
- Routing sweep: localAddress = 4'b0101; push one packet each with dest net 4'b1001, 4'b0001, 4'b0110, 4'b0100, 4'b0101 (read = 1) → sel = 5'b00100, 5'b01000, 5'b00010, 5'b00001, 5'b10000 respectively, fields match inputs, 2-edge latency, one packet per cycle.
- Back-pressure/full: port_full = 5'b00100, push 4 east-bound packets → in_ready drops to 0 after the 4th push with no sel. Release port_full → 4 consecutive east pulses in FIFO order, then in_ready returns to 1.
- Wrap-around: stream 10 packets with data 0..9 at full rate under random 1-cycle east stalls → output order 0..9, none lost or duplicated, pointers wrap cleanly.
- Malformed: push read = 1/write = 1, then read = 0/write = 0, then a valid write → two err_malformed pulses, dropCount = 2, only the third packet dispatched. Force 300 drops → dropCount stays at 255.
- Reset mid-operation: 3 packets queued, target blocked; assert reset for 1 cycle → sel = 0, all outputs 0, in_ready low during reset and 1 after, no queued packet ever dispatched.
- Head-of-line: head east-bound with east full, next packet local-bound → no dispatch until east frees; then east is dispatched first, then local.
